// File: rtl/mac_stream_if.sv
// Groups the vector-memory read bus, the mac1 operand/result bus and the result stream port.
// master = mac_stream_driver side, slave = memory/mac1/consumer side.
interface mac_stream_if #(
  parameter int DATA_W = 128,
  parameter int SUM_W  = 20,
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_p;
  logic [DATA_W-1:0] mem_w;
  logic [DATA_W-1:0] p_out;
  logic [DATA_W-1:0] w_out;
  logic [SUM_W-1:0]  s_in;
  logic [SUM_W-1:0]  res_data;
  logic              res_valid;
  logic              res_ready;
  logic              res_last;

  modport master (
    output mem_addr, mem_rd, p_out, w_out, res_data, res_valid, res_last,
    input  mem_p, mem_w, s_in, res_ready
  );
  modport slave (
    input  mem_addr, mem_rd, p_out, w_out, res_data, res_valid, res_last,
    output mem_p, mem_w, s_in, res_ready
  );
endinterface

// File: rtl/mac_stream_driver.sv
// Streams num_vec (pixel, weight) vector pairs from vector memory into mac1 and collects
// the mac1 results into a small credit-managed FIFO drained through a valid/ready port.
module mac_stream_driver #(
  parameter int DATA_W  = 128,
  parameter int SUM_W   = 20,
  parameter int ADDR_W  = 6,
  parameter int MAC_LAT = 1,
  parameter int DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_vec,
  output logic              busy,
  output logic              done,
  mac_stream_if.master      bus
);
  localparam int STAGES = MAC_LAT;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W:0]   num_r, idx;
  logic              issue, last_issue, push, pop, head_last;
  // vld_pipe[k] set means a read was issued k+1 cycles ago; last_pipe tags the final vector
  logic [STAGES:0]   vld_pipe, last_pipe;
  logic [CW-1:0]     inflight, count;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [SUM_W:0]    fifo_q [DEPTH];
  logic [DATA_W-1:0] p_q, w_q;

  // Pops never free credit in the same cycle, so the FIFO can never be overrun
  assign last_issue = (idx + (ADDR_W+1)'(1)) == num_r;
  assign push       = vld_pipe[STAGES];
  assign pop        = (count != '0) && bus.res_ready;
  assign head_last  = fifo_q[rd_ptr][SUM_W];

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    case (state)
      IDLE:  if (start) state_n = (num_vec == '0) ? FIN : RUN;
      RUN: begin
        issue = ({1'b0, inflight} + {1'b0, count}) < (CW+1)'(DEPTH);
        if (issue && last_issue) state_n = DRAIN;
      end
      DRAIN: if (pop && head_last) state_n = FIN;
      FIN:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base_r    <= '0;
      num_r     <= '0;
      idx       <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
      p_q       <= '0;
      w_q       <= '0;
      inflight  <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      state     <= state_n;
      if (state == IDLE && start) begin
        base_r <= base_addr;
        num_r  <= num_vec;
        idx    <= '0;
      end else if (issue) begin
        idx <= idx + (ADDR_W+1)'(1);
      end
      vld_pipe  <= {vld_pipe[STAGES-1:0], issue};
      last_pipe <= {last_pipe[STAGES-1:0], issue && last_issue};
      if (vld_pipe[0]) begin
        p_q <= bus.mem_p;
        w_q <= bus.mem_w;
      end
      case ({issue, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Storage needs no reset: it is only visible through res_valid-gated outputs
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= {last_pipe[STAGES], bus.s_in};
  end

  assign bus.mem_rd    = issue;
  assign bus.mem_addr  = base_r + idx[ADDR_W-1:0];
  assign bus.p_out     = p_q;
  assign bus.w_out     = w_q;
  assign bus.res_valid = (count != '0);
  assign bus.res_data  = bus.res_valid ? fifo_q[rd_ptr][SUM_W-1:0] : '0;
  assign bus.res_last  = bus.res_valid && head_last;
  assign busy          = (state != IDLE);
  assign done          = (state == FIN);
endmodule

// File: tb/tb_mac_stream_driver.sv
// Directed bench: sync-read vector memory and a combinational 16-lane dot-product mac1 model
// around mac_stream_driver; results compared against golden dot products of the memory.
module tb_mac_stream_driver;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [5:0] base_addr;
  logic [6:0] num_vec;
  logic       busy, done;
  int         n_assert = 0;
  int         n_fail   = 0;

  logic [127:0] pm [64];
  logic [127:0] wm [64];

  mac_stream_if #(.DATA_W(128), .SUM_W(20), .ADDR_W(6)) bus ();

  mac_stream_driver #(.DATA_W(128), .SUM_W(20), .ADDR_W(6), .MAC_LAT(1), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_vec(num_vec),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] dot(input logic [127:0] p, input logic [127:0] w);
    int acc;
    acc = 0;
    for (int i = 0; i < 16; i++) acc += int'(p[i*8 +: 8]) * int'(w[i*8 +: 8]);
    return 20'(acc);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_rd) begin
      bus.mem_p <= pm[bus.mem_addr];
      bus.mem_w <= wm[bus.mem_addr];
    end
  end

  always_comb bus.s_in = dot(bus.p_out, bus.w_out);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_rd"},    128'(bus.mem_rd), 0);
    chk({tag, "_mem_addr"},  128'(bus.mem_addr), 0);
    chk({tag, "_p_out"},     bus.p_out, 0);
    chk({tag, "_w_out"},     bus.w_out, 0);
    chk({tag, "_res_valid"}, 128'(bus.res_valid), 0);
    chk({tag, "_res_data"},  128'(bus.res_data), 0);
    chk({tag, "_res_last"},  128'(bus.res_last), 0);
    chk({tag, "_busy"},      128'(busy), 0);
    chk({tag, "_done"},      128'(done), 0);
  endtask

  // mode 0: ready=1, mode 1: random ready, mode 2: ready=0 for 20 cycles then 1
  task automatic run(input string tag, input int base, input int num, input int mode,
                     input bit inject);
    int nrd = 0, npop = 0, first_rd = -1, last_rd = -1, last_pop = -1, done_cyc = -1;
    logic [5:0] ea;
    base_addr = 6'(base);
    num_vec   = 7'(num);
    start     = 1'b1;
    bus.res_ready = (mode == 0);
    step();
    start     = 1'b0;
    base_addr = 6'(base + 17);
    num_vec   = 7'(num + 3);
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (inject && cyc == 5) begin
        start = 1'b1; base_addr = 6'd7; num_vec = 7'd3;
      end else begin
        start = 1'b0;
      end
      if (bus.mem_rd) begin
        ea = 6'(base + nrd);
        chk({tag, "_addr"}, 128'(bus.mem_addr), 128'(ea));
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        nrd++;
      end
      if (mode == 2 && cyc == 20) begin
        chk({tag, "_stall_reads"}, 128'(nrd), 4);
        chk({tag, "_stall_valid"}, 128'(bus.res_valid), 1);
        chk({tag, "_stall_head"},  128'(bus.res_data), 128'(dot(pm[6'(base)], wm[6'(base)])));
      end
      case (mode)
        0:       bus.res_ready = 1'b1;
        1:       bus.res_ready = 1'($urandom_range(0, 1));
        default: bus.res_ready = (cyc >= 20);
      endcase
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (bus.res_valid && bus.res_ready) begin
        ea = 6'(base + npop);
        chk({tag, "_data"}, 128'(bus.res_data), 128'(dot(pm[ea], wm[ea])));
        chk({tag, "_last"}, 128'(bus.res_last), 128'(npop == num - 1));
        npop++;
        last_pop = cyc;
      end
      step();
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 128'(done_cyc >= 0), 1);
    chk({tag, "_reads"},     128'(nrd), 128'(num));
    chk({tag, "_results"},   128'(npop), 128'(num));
    chk({tag, "_done_lat"},  128'(done_cyc - last_pop), 1);
    if (mode == 0)
      chk({tag, "_rd_contig"}, 128'(last_rd - first_rd + 1), 128'(num));
    step();
    chk({tag, "_done_pulse"}, 128'(done), 0);
    chk({tag, "_idle"},       128'(busy), 0);
  endtask

  initial begin
    for (int a = 0; a < 64; a++)
      for (int i = 0; i < 16; i++) begin
        pm[a][i*8 +: 8] = 8'(a * 37 + i * 11 + 5);
        wm[a][i*8 +: 8] = 8'(a * 19 + i * 29 + 200);
      end
    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_vec = '0; bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("por");
    rst_n = 1'b1;
    step();

    // abort mid-run with three results waiting
    base_addr = 6'd0; num_vec = 7'd10; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    chk("abort_pre_valid", 128'(bus.res_valid), 1);
    chk("abort_pre_busy",  128'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_zero("abort");
    #1;
    rst_n = 1'b1;
    step();
    chk("abort_post_busy",  128'(busy), 0);
    chk("abort_post_valid", 128'(bus.res_valid), 0);
    chk("abort_post_rd",    128'(bus.mem_rd), 0);

    run("stream", 0, 40, 0, 1'b0);
    run("bp",     0, 10, 2, 1'b0);
    run("wrap",  62,  4, 0, 1'b0);

    // zero-length run
    base_addr = 6'd5; num_vec = 7'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("zero_done",  128'(done), 1);
    chk("zero_busy",  128'(busy), 1);
    chk("zero_rd",    128'(bus.mem_rd), 0);
    chk("zero_valid", 128'(bus.res_valid), 0);
    step();
    chk("zero_done_end", 128'(done), 0);
    chk("zero_idle",     128'(busy), 0);
    chk("zero_rd_end",   128'(bus.mem_rd), 0);

    run("toggle", 0, 40, 1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
